// File: rtl/alu_seq_fsm_if.sv
// Instruction handshake and register/ALU strobe bundle for alu_seq_fsm.
// The controlling side (master) issues instructions; the sequencer (slave)
// answers with the per-cycle register-file and ALU strobes.
interface alu_seq_fsm_if #(
  parameter int NREG  = 5,
  parameter int IDX_W = 6,
  parameter int OP_W  = 3
);
  logic             start;
  logic             imm_mode;
  logic [OP_W-1:0]  op_code;
  logic [IDX_W-1:0] ri;
  logic [IDX_W-1:0] rj_imm;

  logic [NREG-1:0]  reg_read;
  logic [NREG-1:0]  reg_write;
  logic [OP_W-1:0]  alu_op;
  logic             alu_write_in1;
  logic             alu_write_in2;
  logic             alu_out_en;
  logic             alu_read;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, imm_mode, op_code, ri, rj_imm,
    input  reg_read, reg_write, alu_op, alu_write_in1, alu_write_in2,
           alu_out_en, alu_read, busy, done, err
  );

  modport slave (
    input  start, imm_mode, op_code, ri, rj_imm,
    output reg_read, reg_write, alu_op, alu_write_in1, alu_write_in2,
           alu_out_en, alu_read, busy, done, err
  );
endinterface

// File: rtl/alu_seq_fsm.sv
// Bus sequencer for a single-bus ALU datapath. One accepted instruction
// walks IN1 -> IN2 -> EVAL -> OUT -> DONE, moving Ri (and Rj or the
// immediate) into the ALU input latches, evaluating, and writing the
// result back into Ri. Illegal register indices divert to a one-cycle ERR.
// All strobes are registered together with the state they belong to, so
// every output is a function of the current state and latched fields only.
module alu_seq_fsm #(
  parameter int DATA_W = 16,
  parameter int NREG   = 5,
  parameter int IDX_W  = 6,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  alu_seq_fsm_if.slave      ctl,
  output wire  [DATA_W-1:0] out_to_bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IN1  = 3'd1,
    IN2  = 3'd2,
    EVAL = 3'd3,
    OUT  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t           state_r;
  logic             imm_r;
  logic [OP_W-1:0]  op_r;
  logic [IDX_W-1:0] ri_r;
  logic [IDX_W-1:0] rj_r;

  logic [NREG-1:0]  reg_read_r;
  logic [NREG-1:0]  reg_write_r;
  logic [OP_W-1:0]  alu_op_r;
  logic             wr_in1_r;
  logic             wr_in2_r;
  logic             out_en_r;
  logic             alu_read_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             bus_en_r;

  // One-hot select for a register index; indices >= NREG select nothing.
  function automatic logic [NREG-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NREG-1:0] v;
    v = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      v[i] = (idx == IDX_W'(i));
    end
    return v;
  endfunction

  // An instruction is illegal if Ri, or Rj when used as a register, is out of range.
  function automatic logic is_illegal(input logic             imm,
                                      input logic [IDX_W-1:0] a,
                                      input logic [IDX_W-1:0] b);
    return (int'(a) >= NREG) || (!imm && (int'(b) >= NREG));
  endfunction

  // Sequencer state, latched instruction fields and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      imm_r       <= 1'b0;
      op_r        <= {OP_W{1'b0}};
      ri_r        <= {IDX_W{1'b0}};
      rj_r        <= {IDX_W{1'b0}};
      reg_read_r  <= {NREG{1'b0}};
      reg_write_r <= {NREG{1'b0}};
      alu_op_r    <= {OP_W{1'b0}};
      wr_in1_r    <= 1'b0;
      wr_in2_r    <= 1'b0;
      out_en_r    <= 1'b0;
      alu_read_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      bus_en_r    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless the state being entered sets them.
      reg_read_r  <= {NREG{1'b0}};
      reg_write_r <= {NREG{1'b0}};
      alu_op_r    <= {OP_W{1'b0}};
      wr_in1_r    <= 1'b0;
      wr_in2_r    <= 1'b0;
      out_en_r    <= 1'b0;
      alu_read_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      bus_en_r    <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (ctl.start) begin
            imm_r  <= ctl.imm_mode;
            op_r   <= ctl.op_code;
            ri_r   <= ctl.ri;
            rj_r   <= ctl.rj_imm;
            busy_r <= 1'b1;
            if (is_illegal(ctl.imm_mode, ctl.ri, ctl.rj_imm)) begin
              state_r <= ERR;
              err_r   <= 1'b1;
            end else begin
              state_r    <= IN1;
              reg_read_r <= idx_onehot(ctl.ri);
              wr_in1_r   <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            imm_r   <= 1'b0;
            op_r    <= {OP_W{1'b0}};
            ri_r    <= {IDX_W{1'b0}};
            rj_r    <= {IDX_W{1'b0}};
          end
        end
        IN1: begin
          state_r  <= IN2;
          busy_r   <= 1'b1;
          wr_in2_r <= 1'b1;
          if (imm_r) begin
            bus_en_r <= 1'b1;
          end else begin
            reg_read_r <= idx_onehot(rj_r);
          end
        end
        IN2: begin
          state_r  <= EVAL;
          busy_r   <= 1'b1;
          alu_op_r <= op_r;
          out_en_r <= 1'b1;
        end
        EVAL: begin
          state_r     <= OUT;
          busy_r      <= 1'b1;
          alu_read_r  <= 1'b1;
          reg_write_r <= idx_onehot(ri_r);
        end
        OUT: begin
          state_r <= DONE;
          busy_r  <= 1'b1;
          done_r  <= 1'b1;
        end
        ERR: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          imm_r   <= 1'b0;
          op_r    <= {OP_W{1'b0}};
          ri_r    <= {IDX_W{1'b0}};
          rj_r    <= {IDX_W{1'b0}};
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          imm_r   <= 1'b0;
          op_r    <= {OP_W{1'b0}};
          ri_r    <= {IDX_W{1'b0}};
          rj_r    <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // The immediate is zero-extended (or truncated) to the bus width.
  assign out_to_bus = bus_en_r ? DATA_W'(rj_r) : {DATA_W{1'bz}};

  assign ctl.reg_read      = reg_read_r;
  assign ctl.reg_write     = reg_write_r;
  assign ctl.alu_op        = alu_op_r;
  assign ctl.alu_write_in1 = wr_in1_r;
  assign ctl.alu_write_in2 = wr_in2_r;
  assign ctl.alu_out_en    = out_en_r;
  assign ctl.alu_read      = alu_read_r;
  assign ctl.busy          = busy_r;
  assign ctl.done          = done_r;
  assign ctl.err           = err_r;

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Self-checking bench for alu_seq_fsm: directed and randomized instructions
// compared cycle by cycle against a phase-based reference model.
module tb_alu_seq_fsm;
  localparam int DATA_W = 16;
  localparam int NREG   = 5;
  localparam int IDX_W  = 6;
  localparam int OP_W   = 3;
  localparam int VW     = 2 * NREG + OP_W + 7;

  // Phase numbering of the model: 0 idle, 1..5 the five legal cycles, 6 error.
  localparam int PH_IDLE = 0;
  localparam int PH_ERR  = 6;

  typedef struct packed {
    logic             imm;
    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] ri;
    logic [IDX_W-1:0] rj;
  } instr_t;

  logic clk;
  logic reset;
  wire  [DATA_W-1:0] out_to_bus;
  int   cmps;
  int   fails;

  alu_seq_fsm_if #(.NREG(NREG), .IDX_W(IDX_W), .OP_W(OP_W)) bus_if ();

  alu_seq_fsm #(.DATA_W(DATA_W), .NREG(NREG), .IDX_W(IDX_W), .OP_W(OP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctl        (bus_if.slave),
    .out_to_bus (out_to_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic legal(instr_t x);
    return (int'(x.ri) < NREG) && (x.imm || (int'(x.rj) < NREG));
  endfunction

  function automatic logic [NREG-1:0] sel(logic [IDX_W-1:0] idx);
    logic [NREG-1:0] one;
    one = {{(NREG-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  function automatic int ph_of(instr_t x, int p);
    return legal(x) ? p : PH_ERR;
  endfunction

  function automatic int nph(instr_t x);
    return legal(x) ? 5 : 1;
  endfunction

  function automatic logic [VW-1:0] exp_vec(int ph, instr_t x);
    logic [NREG-1:0] rr;
    logic [NREG-1:0] rw;
    logic [OP_W-1:0] aop;
    rr  = (ph == 1) ? sel(x.ri) : ((ph == 2 && !x.imm) ? sel(x.rj) : {NREG{1'b0}});
    rw  = (ph == 4) ? sel(x.ri) : {NREG{1'b0}};
    aop = (ph == 3) ? x.op : {OP_W{1'b0}};
    return {rr, rw, aop, ph == 1, ph == 2, ph == 3, ph == 4,
            ph != PH_IDLE, ph == 5, ph == PH_ERR};
  endfunction

  function automatic logic [DATA_W-1:0] exp_bus(int ph, instr_t x);
    if (ph == 2 && x.imm) return DATA_W'(x.rj);
    return {DATA_W{1'bz}};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus_if.reg_read, bus_if.reg_write, bus_if.alu_op,
            bus_if.alu_write_in1, bus_if.alu_write_in2, bus_if.alu_out_en,
            bus_if.alu_read, bus_if.busy, bus_if.done, bus_if.err};
  endfunction

  function automatic instr_t rand_instr(int max_idx);
    instr_t x;
    x.imm = 1'($urandom_range(0, 1));
    x.op  = OP_W'($urandom);
    x.ri  = IDX_W'($urandom_range(0, max_idx));
    x.rj  = x.imm ? IDX_W'($urandom) : IDX_W'($urandom_range(0, max_idx));
    return x;
  endfunction

  // ---------------- drive helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(instr_t x, logic s);
    bus_if.start    = s;
    bus_if.imm_mode = x.imm;
    bus_if.op_code  = x.op;
    bus_if.ri       = x.ri;
    bus_if.rj_imm   = x.rj;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    instr_t z;
    z = '{imm: 1'b0, op: 3'd0, ri: 6'd0, rj: 6'd0};
    reset = 1'b1;
    apply(z, 1'b0);
    for (int c = 0; c < 2; c++) begin
      step();
      cmps++;
      if (obs_vec() !== exp_vec(PH_IDLE, z) || out_to_bus !== exp_bus(PH_IDLE, z)) begin
        fails++;
        $display("FAIL reset c%0d: got %b bus %h, need %b bus %h", c,
                 obs_vec(), out_to_bus, exp_vec(PH_IDLE, z), exp_bus(PH_IDLE, z));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_imm_directed();
    instr_t x;
    x = '{imm: 1'b1, op: 3'd1, ri: 6'd2, rj: 6'd9};
    apply(x, 1'b1);
    step();
    for (int p = 1; p <= 6; p++) begin
      int ph;
      ph = (p == 6) ? PH_IDLE : p;
      cmps++;
      if (obs_vec() !== exp_vec(ph, x) || out_to_bus !== exp_bus(ph, x)) begin
        fails++;
        $display("FAIL imm_directed ph%0d: got %b bus %h, need %b bus %h", ph,
                 obs_vec(), out_to_bus, exp_vec(ph, x), exp_bus(ph, x));
      end
      if (p == 2) begin
        cmps++;
        if (out_to_bus !== 16'h0009) begin
          fails++;
          $display("FAIL imm_bus_value: got %h, need 0009", out_to_bus);
        end
      end
      bus_if.start = 1'b0;
      if (p < 6) step();
    end
  endtask

  task automatic test_reg_directed();
    instr_t x;
    x = '{imm: 1'b0, op: 3'd5, ri: 6'd0, rj: 6'd3};
    apply(x, 1'b1);
    step();
    for (int p = 1; p <= 6; p++) begin
      int ph;
      ph = (p == 6) ? PH_IDLE : p;
      cmps++;
      if (obs_vec() !== exp_vec(ph, x) || out_to_bus !== exp_bus(ph, x)) begin
        fails++;
        $display("FAIL reg_directed ph%0d: got %b bus %h, need %b bus %h", ph,
                 obs_vec(), out_to_bus, exp_vec(ph, x), exp_bus(ph, x));
      end
      // Busy-time start pulses with changed ri/op must be ignored.
      if (p < 5) apply('{imm: 1'b1, op: 3'd2, ri: 6'd4, rj: 6'd1}, 1'b1);
      else       bus_if.start = 1'b0;
      if (p < 6) step();
    end
  endtask

  task automatic test_illegal();
    instr_t tbl [4];
    tbl[0] = '{imm: 1'b0, op: 3'd2, ri: 6'd5,  rj: 6'd0};
    tbl[1] = '{imm: 1'b0, op: 3'd3, ri: 6'd1,  rj: 6'd7};
    tbl[2] = '{imm: 1'b1, op: 3'd4, ri: 6'd63, rj: 6'd0};
    tbl[3] = '{imm: 1'b1, op: 3'd6, ri: 6'd4,  rj: 6'd63};
    for (int k = 0; k < 4; k++) begin
      apply(tbl[k], 1'b1);
      step();
      for (int p = 1; p <= nph(tbl[k]) + 1; p++) begin
        int ph;
        ph = (p > nph(tbl[k])) ? PH_IDLE : ph_of(tbl[k], p);
        cmps++;
        if (obs_vec() !== exp_vec(ph, tbl[k]) || out_to_bus !== exp_bus(ph, tbl[k])) begin
          fails++;
          $display("FAIL illegal k%0d ph%0d: got %b bus %h, need %b bus %h", k, ph,
                   obs_vec(), out_to_bus, exp_vec(ph, tbl[k]), exp_bus(ph, tbl[k]));
        end
        // start during ERR is ignored; during DONE it is dropped here.
        bus_if.start = (ph == PH_ERR) ? 1'b1 : 1'b0;
        if (p <= nph(tbl[k])) step();
      end
      bus_if.start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    instr_t q [$];
    for (int k = 0; k < 5; k++) q.push_back(rand_instr(NREG - 1));
    apply(q[0], 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      for (int p = 1; p <= 5; p++) begin
        cmps++;
        if (obs_vec() !== exp_vec(p, q[k]) || out_to_bus !== exp_bus(p, q[k])) begin
          fails++;
          $display("FAIL back_to_back i%0d ph%0d: got %b bus %h, need %b bus %h", k, p,
                   obs_vec(), out_to_bus, exp_vec(p, q[k]), exp_bus(p, q[k]));
        end
        if (p < 5)      apply(rand_instr(7), 1'b1);
        else if (k < 4) apply(q[k + 1], 1'b1);
        else            bus_if.start = 1'b0;
        step();
      end
    end
    cmps++;
    if (obs_vec() !== exp_vec(PH_IDLE, q[4])) begin
      fails++;
      $display("FAIL back_to_back_end: got %b, need %b", obs_vec(), exp_vec(PH_IDLE, q[4]));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      instr_t x;
      int gap;
      x = rand_instr(6);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        apply(rand_instr(7), 1'b0);
        step();
        cmps++;
        if (obs_vec() !== exp_vec(PH_IDLE, x) || out_to_bus !== exp_bus(PH_IDLE, x)) begin
          fails++;
          $display("FAIL random_gap i%0d: got %b bus %h, need %b", k,
                   obs_vec(), out_to_bus, exp_vec(PH_IDLE, x));
        end
      end
      apply(x, 1'b1);
      step();
      for (int p = 1; p <= nph(x); p++) begin
        int ph;
        ph = ph_of(x, p);
        cmps++;
        if (obs_vec() !== exp_vec(ph, x) || out_to_bus !== exp_bus(ph, x)) begin
          fails++;
          $display("FAIL random i%0d ph%0d instr %h: got %b bus %h, need %b bus %h", k, ph, x,
                   obs_vec(), out_to_bus, exp_vec(ph, x), exp_bus(ph, x));
        end
        if (ph == 5) apply(rand_instr(7), 1'b0);
        else         apply(rand_instr(7), 1'($urandom_range(0, 1)));
        step();
      end
      cmps++;
      if (obs_vec() !== exp_vec(PH_IDLE, x) || out_to_bus !== exp_bus(PH_IDLE, x)) begin
        fails++;
        $display("FAIL random_idle i%0d: got %b bus %h, need %b", k,
                 obs_vec(), out_to_bus, exp_vec(PH_IDLE, x));
      end
      bus_if.start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    instr_t x;
    x = '{imm: 1'b0, op: 3'd7, ri: 6'd3, rj: 6'd1};
    apply(x, 1'b1);
    step();
    bus_if.start = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      cmps++;
      if (obs_vec() !== exp_vec(p, x)) begin
        fails++;
        $display("FAIL reset_mid ph%0d: got %b, need %b", p, obs_vec(), exp_vec(p, x));
      end
      if (p < 3) step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cmps++;
      if (obs_vec() !== exp_vec(PH_IDLE, x) || out_to_bus !== exp_bus(PH_IDLE, x)) begin
        fails++;
        $display("FAIL reset_mid_idle c%0d: got %b bus %h, need %b", c,
                 obs_vec(), out_to_bus, exp_vec(PH_IDLE, x));
      end
      step();
    end
    // Reset wins over a simultaneous start.
    apply(x, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_if.start = 1'b0;
    cmps++;
    if (obs_vec() !== exp_vec(PH_IDLE, x)) begin
      fails++;
      $display("FAIL reset_priority: got %b, need %b", obs_vec(), exp_vec(PH_IDLE, x));
    end
    step();
    cmps++;
    if (obs_vec() !== exp_vec(PH_IDLE, x)) begin
      fails++;
      $display("FAIL reset_priority_after: got %b, need %b", obs_vec(), exp_vec(PH_IDLE, x));
    end
  endtask

  initial begin
    cmps  = 0;
    fails = 0;
    reset = 1'b1;
    bus_if.start    = 1'b0;
    bus_if.imm_mode = 1'b0;
    bus_if.op_code  = 3'd0;
    bus_if.ri       = 6'd0;
    bus_if.rj_imm   = 6'd0;
    test_reset();
    test_imm_directed();
    test_reg_directed();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_fsm.md
ALU_SEQ_FSM -- requirements
Module: alu_seq_fsm

Interface
REQ-001 Parameter DATA_W, default 16, bus and immediate-extension width.
REQ-002 Parameter NREG, default 5, number of addressable bus registers, indices 0..NREG-1 (index NREG-1 = P0).
REQ-003 Parameter IDX_W, default 6, width of register-index and immediate fields.
REQ-004 Parameter OP_W, default 3, width of ALU operation code.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to execute one instruction.
REQ-008 imm_mode  input  1  1 = Ri <- Ri op imm; 0 = Ri <- Ri op Rj.
REQ-009 op_code  input  OP_W  ALU operation.
REQ-010 ri  input  IDX_W  destination / first-source register index.
REQ-011 rj_imm  input  IDX_W  second-source register index (imm_mode=0) or immediate (imm_mode=1).
REQ-012 out_to_bus  output  DATA_W  tri-state bus drive; high-Z unless driving the immediate.
REQ-013 reg_read  output  NREG  one-hot register-to-bus read enables.
REQ-014 reg_write  output  NREG  one-hot bus-to-register write enables.
REQ-015 alu_op  output  OP_W  ALU operation select.
REQ-016 alu_write_in1, alu_write_in2, alu_out_en, alu_read  output  1 each  ALU input latch, evaluate, and result-to-bus strobes.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  one-cycle illegal-index pulse.

Function
REQ-020 States SHALL be IDLE, IN1, IN2, EVAL, OUT, DONE, ERR; all outputs SHALL be decoded from the registered state and latched fields only (Moore).
REQ-021 On start sampled high in IDLE or DONE, op_code, imm_mode, ri, rj_imm SHALL be latched; later input changes SHALL not affect the instruction in flight.
REQ-022 Legality check at acceptance: ri >= NREG, or imm_mode=0 with rj_imm >= NREG, SHALL go to ERR, else IN1.
REQ-023 ERR: err=1, no other strobes, next state IDLE; start ignored in ERR.
REQ-024 IN1: reg_read[ri]=1, alu_write_in1=1.
REQ-025 IN2, imm_mode=1: out_to_bus = rj_imm zero-extended to DATA_W, alu_write_in2=1, reg_read=0.
REQ-026 IN2, imm_mode=0: reg_read[rj]=1, alu_write_in2=1, out_to_bus high-Z.
REQ-027 EVAL: alu_op=latched op_code, alu_out_en=1; alu_op SHALL be 0 in all other states.
REQ-028 OUT: alu_read=1, reg_write[ri]=1.
REQ-029 DONE: done=1; start high in DONE SHALL be accepted (back-to-back), else next state IDLE.
REQ-030 Latency: start accepted at edge N -> IN1 cycle N+1, done high cycle N+5; back-to-back throughput 5 cycles/instruction.
REQ-031 start while busy in IN1..OUT SHALL be ignored without queuing.
REQ-032 At most one bit of reg_read and reg_write SHALL be high in any cycle; both SHALL be 0 outside IN1/IN2/OUT.
REQ-033 If ri == rj (imm_mode=0) the same register SHALL be read in IN1 and IN2 and written in OUT; no special case.
REQ-034 If DATA_W < IDX_W the immediate SHALL be truncated to its low DATA_W bits.

Reset
REQ-035 reset sampled high SHALL force IDLE at that edge regardless of state, including mid-instruction; no write strobe SHALL follow.
REQ-036 In IDLE/reset: all strobes, busy, done, err, alu_op = 0; out_to_bus high-Z; latched fields = 0.
REQ-037 reset SHALL take priority over start on the same edge.

Verification
REQ-038 imm_mode=1, ri=2, rj_imm=6'd9, op=3'd1 -> reg_read[2] cycle 1, bus=16'h0009 cycle 2, alu_op=1 cycle 3, reg_write[2]+alu_read cycle 4, done cycle 5.
REQ-039 imm_mode=0, ri=0, rj_imm=3 -> reg_read=5'b00001 in IN1, 5'b01000 in IN2, bus high-Z throughout, reg_write=5'b00001 in OUT.
REQ-040 ri=5 with NREG=5 -> err high one cycle after acceptance, no reg_read/reg_write ever asserted, IDLE next.
REQ-041 start held high continuously -> done every 5 cycles, IN1 follows DONE directly, busy never drops.
REQ-042 reset asserted during EVAL -> next cycle IDLE, all outputs 0, bus high-Z, reg_write never asserted.
REQ-043 ri/op_code changed during IN2 -> OUT writes originally latched ri, EVAL uses original op_code.
